// File: rtl/serial_adder_unit.sv
// serial_adder_unit: bit-serial adder/subtractor. Operands are latched on
// accept, then one bit per clock is pushed LSB-first through a single 1-bit
// full adder with a registered carry. Results and flags are registered and
// held until the next completed operation or reset.
module serial_adder_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic             Sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf,
    output logic             Zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] s_sh_r;
    logic [WIDTH-1:0] s_next_s;
    logic             carry_r;
    logic             c_msb_r;
    logic [CW-1:0]    cnt_r;
    logic             fa_sum_s;
    logic             fa_cout_s;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] s_out_r;
    logic             cout_r;
    logic             ovf_r;
    logic             zero_r;

    // The one and only adder cell; everything else is sequencing around it.
    Full_Adder u_fa (
        .a    (a_sh_r[0]),
        .b    (b_sh_r[0]),
        .cin  (carry_r),
        .sum  (fa_sum_s),
        .cout (fa_cout_s)
    );

    // Result shift register value after this step: new bit enters at the MSB.
    always_comb begin
        s_next_s = {fa_sum_s, s_sh_r[WIDTH-1:1]};
    end

    // Next-state logic: accept in IDLE, exit RUN on the last bit, DONE lasts one cycle.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (Start) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == CNT_LAST) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register plus status outputs registered from the upcoming state.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != IDLE);
            done_r  <= (state_s == DONE);
        end
    end

    // Datapath: operand latch on accept, one serial step per clock in RUN.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            a_sh_r  <= {WIDTH{1'b0}};
            b_sh_r  <= {WIDTH{1'b0}};
            s_sh_r  <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            c_msb_r <= 1'b0;
            cnt_r   <= {CW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (Start) begin
                        a_sh_r  <= A;
                        // Subtraction as A + ~B + 1: the +1 rides in on the carry.
                        b_sh_r  <= Sub ? ~B : B;
                        carry_r <= Sub;
                        cnt_r   <= {CW{1'b0}};
                    end
                end
                RUN: begin
                    s_sh_r  <= s_next_s;
                    a_sh_r  <= {1'b0, a_sh_r[WIDTH-1:1]};
                    b_sh_r  <= {1'b0, b_sh_r[WIDTH-1:1]};
                    carry_r <= fa_cout_s;
                    cnt_r   <= cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
                        // Carry into the MSB is needed for signed overflow.
                        c_msb_r <= carry_r;
                    end
                end
                default: ;
            endcase
        end
    end

    // Result/flag registers: loaded on the final step so they are valid in DONE,
    // then held until the next completion; a new accept does not clear them.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            s_out_r <= {WIDTH{1'b0}};
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
            zero_r  <= 1'b0;
        end else if ((state_r == RUN) && (cnt_r == CNT_LAST)) begin
            s_out_r <= s_next_s;
            cout_r  <= fa_cout_s;
            ovf_r   <= carry_r ^ fa_cout_s;
            zero_r  <= (s_next_s == {WIDTH{1'b0}});
        end
    end

    assign Busy = busy_r;
    assign Done = done_r;
    assign S    = s_out_r;
    assign Cout = cout_r;
    assign Ovf  = ovf_r;
    assign Zero = zero_r;

endmodule

// Single-bit full adder cell used by the serial datapath.
module Full_Adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: tb/tb_serial_adder_unit.sv
// Directed bench for serial_adder_unit at WIDTH=8 with hand-computed results.
module tb_serial_adder_unit;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       Start = 1'b0;
    logic       Sub = 1'b0;
    logic [7:0] A = 8'h00;
    logic [7:0] B = 8'h00;
    logic       Busy;
    logic       Done;
    logic [7:0] S;
    logic       Cout;
    logic       Ovf;
    logic       Zero;

    int n_checks = 0;
    int n_fail   = 0;

    serial_adder_unit #(.WIDTH(8)) dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .Start (Start),
        .Sub   (Sub),
        .A     (A),
        .B     (B),
        .Busy  (Busy),
        .Done  (Done),
        .S     (S),
        .Cout  (Cout),
        .Ovf   (Ovf),
        .Zero  (Zero)
    );

    always #5 Clk = ~Clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Issue one operation from IDLE and wait for Done (bounded); check latency,
    // Busy length and all results on the Done cycle, then step back to IDLE.
    task automatic run_op(input string tag, input logic [7:0] a_v, input logic [7:0] b_v,
                          input logic sub_v, input logic [7:0] exp_s, input logic exp_c,
                          input logic exp_o, input logic exp_z);
        int cycles;
        int busy_cnt;
        A = a_v; B = b_v; Sub = sub_v; Start = 1'b1;
        tick();
        Start = 1'b0;
        A = 8'hA5; B = 8'h5A; Sub = ~sub_v;
        cycles = 0;
        busy_cnt = (Busy === 1'b1) ? 1 : 0;
        while ((Done !== 1'b1) && (cycles < 20)) begin
            tick();
            cycles++;
            if (Busy === 1'b1) busy_cnt++;
        end
        check_value({tag, "_latency"}, cycles, 8);
        check_value({tag, "_busy_len"}, busy_cnt, 9);
        check_value({tag, "_s"}, {24'h0, S}, {24'h0, exp_s});
        check_value({tag, "_cout"}, {31'h0, Cout}, {31'h0, exp_c});
        check_value({tag, "_ovf"}, {31'h0, Ovf}, {31'h0, exp_o});
        check_value({tag, "_zero"}, {31'h0, Zero}, {31'h0, exp_z});
        tick();
        check_value({tag, "_busy_fall"}, {31'h0, Busy}, 32'h0);
        check_value({tag, "_done_pulse"}, {31'h0, Done}, 32'h0);
        check_value({tag, "_s_hold"}, {24'h0, S}, {24'h0, exp_s});
    endtask

    initial begin
        int done_cnt;
        int last_done;
        logic [7:0] s_at_done;

        // Reset state
        tick();
        tick();
        check_value("rst_busy", {31'h0, Busy}, 32'h0);
        check_value("rst_done", {31'h0, Done}, 32'h0);
        check_value("rst_s", {24'h0, S}, 32'h0);
        check_value("rst_cout", {31'h0, Cout}, 32'h0);
        check_value("rst_ovf", {31'h0, Ovf}, 32'h0);
        check_value("rst_zero", {31'h0, Zero}, 32'h0);
        Rst = 1'b0;
        tick();

        // Add / subtract vectors
        run_op("add_0f_01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0);
        run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        run_op("sub_05_05", 8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
        run_op("sub_03_05", 8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
        run_op("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);

        // Start during RUN is ignored; operand/Sub changes ignored
        A = 8'h12; B = 8'h34; Sub = 1'b0; Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        tick();
        A = 8'hFF; Sub = 1'b1; Start = 1'b1;
        tick();
        Start = 1'b0;
        done_cnt = 0;
        s_at_done = 8'h00;
        for (int i = 0; i < 20; i++) begin
            if (Done === 1'b1) begin
                done_cnt++;
                s_at_done = S;
            end
            tick();
        end
        check_value("ign_done_count", done_cnt, 1);
        check_value("ign_s", {24'h0, s_at_done}, 32'h46);

        // Reset mid-RUN aborts
        A = 8'h55; B = 8'h11; Sub = 1'b0; Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        tick();
        tick();
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        check_value("abort_busy", {31'h0, Busy}, 32'h0);
        check_value("abort_done", {31'h0, Done}, 32'h0);
        check_value("abort_s", {24'h0, S}, 32'h0);
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (Done === 1'b1) done_cnt++;
            tick();
        end
        check_value("abort_no_done", done_cnt, 0);
        run_op("post_rst_add", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0);

        // Start held high: one result every 10 clocks
        A = 8'h10; B = 8'h20; Sub = 1'b0; Start = 1'b1;
        done_cnt = 0;
        last_done = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (Done === 1'b1) begin
                done_cnt++;
                check_value("held_s", {24'h0, S}, 32'h30);
                if (done_cnt > 1) check_value("held_period", i - last_done, 10);
                last_done = i;
            end
            if (i == 14) begin
                check_value("held_s_between", {24'h0, S}, 32'h30);
                check_value("held_cout_between", {31'h0, Cout}, 32'h0);
                check_value("held_zero_between", {31'h0, Zero}, 32'h0);
            end
        end
        Start = 1'b0;
        check_value("held_done_count", done_cnt, 3);
        for (int i = 0; i < 12; i++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
